softmax_argmax: RTL and testbench

SOFTMAX_ARGMAX -- requirements
Module: softmax_argmax

---
 rtl/softmax_argmax_if.sv | 26 ++
 rtl/softmax_argmax.sv | 167 ++++++++++++++++
 tb/tb_softmax_argmax.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/softmax_argmax_if.sv
// rtl/softmax_argmax_if.sv - probability-vector in / winning-class out handshake bundle
interface softmax_argmax_if;
  logic        valid_in;
  logic [31:0] class0;
  logic [31:0] class1;
  logic [31:0] class2;
  logic [31:0] class3;
  logic [31:0] class4;
  logic [31:0] class5;
  logic [31:0] class6;
  logic        ready;
  logic        valid_out;
  logic [2:0]  class_idx;
  logic [31:0] max_val;
  logic        nan_flag;

  modport master (
    output valid_in, class0, class1, class2, class3, class4, class5, class6,
    input  ready, valid_out, class_idx, max_val, nan_flag
  );

  modport slave (
    input  valid_in, class0, class1, class2, class3, class4, class5, class6,
    output ready, valid_out, class_idx, max_val, nan_flag
  );
endinterface

// File: rtl/softmax_argmax.sv
// rtl/softmax_argmax.sv - sequential float32 argmax over seven softmax class probabilities
module softmax_argmax (
  input  logic             clk,
  input  logic             rst,
  softmax_argmax_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] cap_q [7];
  logic [31:0] cap_d [7];
  logic [31:0] best_q, best_d;
  logic [2:0]  best_idx_q, best_idx_d;
  logic [2:0]  idx_q, idx_d;
  logic        nan_cap_q, nan_cap_d;
  logic        ready_q, ready_d;
  logic        valid_out_q, valid_out_d;
  logic [2:0]  class_idx_q, class_idx_d;
  logic [31:0] max_val_q, max_val_d;
  logic        nan_flag_q, nan_flag_d;

  logic [31:0] class_in [7];
  logic [31:0] cand;
  logic        take_cand;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Sign-magnitude ordering: +0 and -0 tie, negative magnitudes order inversely.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    logic gt;
    if (a[31] != b[31]) begin
      gt = !a[31] && !((a[30:0] == 31'd0) && (b[30:0] == 31'd0));
    end else if (!a[31]) begin
      gt = a[30:0] > b[30:0];
    end else begin
      gt = a[30:0] < b[30:0];
    end
    return gt;
  endfunction

  // Gather the interface inputs into an indexable array for capture.
  always_comb begin
    class_in[0] = bus.class0;
    class_in[1] = bus.class1;
    class_in[2] = bus.class2;
    class_in[3] = bus.class3;
    class_in[4] = bus.class4;
    class_in[5] = bus.class5;
    class_in[6] = bus.class6;
  end

  // Select the captured candidate under examination and decide whether it beats best.
  always_comb begin
    case (idx_q)
      3'd1:    cand = cap_q[1];
      3'd2:    cand = cap_q[2];
      3'd3:    cand = cap_q[3];
      3'd4:    cand = cap_q[4];
      3'd5:    cand = cap_q[5];
      3'd6:    cand = cap_q[6];
      default: cand = cap_q[0];
    endcase
    if (is_nan(cand)) begin
      take_cand = 1'b0;
    end else if (is_nan(best_q)) begin
      take_cand = 1'b1;
    end else begin
      take_cand = fp_gt(cand, best_q);
    end
  end

  // Next-state logic: capture in IDLE, one candidate per SCAN edge, publish in DONE.
  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    idx_d       = idx_q;
    nan_cap_d   = nan_cap_q;
    ready_d     = ready_q;
    valid_out_d = 1'b0;
    class_idx_d = class_idx_q;
    max_val_d   = max_val_q;
    nan_flag_d  = nan_flag_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          nan_cap_d = 1'b0;
          for (int i = 0; i < 7; i++) begin
            cap_d[i]  = class_in[i];
            nan_cap_d = nan_cap_d | is_nan(class_in[i]);
          end
          best_d     = class_in[0];
          best_idx_d = 3'd0;
          idx_d      = 3'd1;
          ready_d    = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (take_cand) begin
          best_d     = cand;
          best_idx_d = idx_q;
        end
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd6) begin
          state_d = DONE;
        end
      end
      DONE: begin
        class_idx_d = best_idx_q;
        max_val_d   = best_q;
        nan_flag_d  = nan_cap_q;
        valid_out_d = 1'b1;
        ready_d     = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any scan in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < 7; i++) begin
        cap_q[i] <= 32'd0;
      end
      best_q      <= 32'd0;
      best_idx_q  <= 3'd0;
      idx_q       <= 3'd0;
      nan_cap_q   <= 1'b0;
      ready_q     <= 1'b1;
      valid_out_q <= 1'b0;
      class_idx_q <= 3'd0;
      max_val_q   <= 32'd0;
      nan_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < 7; i++) begin
        cap_q[i] <= cap_d[i];
      end
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      idx_q       <= idx_d;
      nan_cap_q   <= nan_cap_d;
      ready_q     <= ready_d;
      valid_out_q <= valid_out_d;
      class_idx_q <= class_idx_d;
      max_val_q   <= max_val_d;
      nan_flag_q  <= nan_flag_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.valid_out = valid_out_q;
  assign bus.class_idx = class_idx_q;
  assign bus.max_val   = max_val_q;
  assign bus.nan_flag  = nan_flag_q;

endmodule

// File: tb/tb_softmax_argmax.sv
// tb/tb_softmax_argmax.sv - directed self-checking bench for softmax_argmax
module tb_softmax_argmax;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  softmax_argmax_if bus ();

  softmax_argmax dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] a3, input logic [31:0] a4, input logic [31:0] a5,
                         input logic [31:0] a6);
    bus.class0 = a0; bus.class1 = a1; bus.class2 = a2; bus.class3 = a3;
    bus.class4 = a4; bus.class5 = a5; bus.class6 = a6;
  endtask

  // Capture one vector, scramble inputs afterwards, and check the 7-edge result timing.
  task automatic run_vec(input string tag,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] a3, input logic [31:0] a4, input logic [31:0] a5,
                         input logic [31:0] a6,
                         input logic [2:0] e_idx, input logic [31:0] e_max, input logic e_nan);
    set_vec(a0, a1, a2, a3, a4, a5, a6);
    bus.valid_in = 1'b1;
    check({tag, " ready_before"}, {31'd0, bus.ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    set_vec(32'h7f7fffff, 32'h7f7fffff, 32'h7f7fffff, 32'h7f7fffff,
            32'h7f7fffff, 32'h7f7fffff, 32'h7f7fffff);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s valid_out_e%0d", tag, k), {31'd0, bus.valid_out}, (k == 7) ? 32'd1 : 32'd0);
      if (k == 6) check({tag, " ready_busy"}, {31'd0, bus.ready}, 32'd0);
      if (k >= 7) begin
        check($sformatf("%s ready_e%0d", tag, k), {31'd0, bus.ready}, 32'd1);
        check($sformatf("%s class_idx_e%0d", tag, k), {29'd0, bus.class_idx}, {29'd0, e_idx});
        check($sformatf("%s max_val_e%0d", tag, k), bus.max_val, e_max);
        check($sformatf("%s nan_flag_e%0d", tag, k), {31'd0, bus.nan_flag}, {31'd0, e_nan});
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.valid_in = 1'b0;
    set_vec(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", {31'd0, bus.ready}, 32'd1);
    check("rst valid_out", {31'd0, bus.valid_out}, 32'd0);
    check("rst class_idx", {29'd0, bus.class_idx}, 32'd0);
    check("rst max_val", bus.max_val, 32'd0);
    check("rst nan_flag", {31'd0, bus.nan_flag}, 32'd0);
    rst = 1'b1;

    run_vec("ascend", 32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h40a00000, 32'h40c00000, 32'h40e00000, 3'd6, 32'h40e00000, 1'b0);
    run_vec("tie_all", 32'h3e124925, 32'h3e124925, 32'h3e124925, 32'h3e124925,
            32'h3e124925, 32'h3e124925, 32'h3e124925, 3'd0, 32'h3e124925, 1'b0);
    run_vec("tie_2_5", 32'h3d000000, 32'h3d000000, 32'h3f000000, 32'h3d000000,
            32'h3d000000, 32'h3f000000, 32'h3d000000, 3'd2, 32'h3f000000, 1'b0);
    run_vec("zeros", 32'h80000000, 32'h00000000, 32'hbf800000, 32'hbf800000,
            32'hbf800000, 32'hbf800000, 32'hbf800000, 3'd0, 32'h80000000, 1'b0);
    run_vec("negs", 32'hc0000000, 32'hc0400000, 32'hc0400000, 32'hc0400000,
            32'hbf800000, 32'hc0400000, 32'hc0400000, 3'd4, 32'hbf800000, 1'b0);
    run_vec("nan_first", 32'h7fc00000, 32'h3e000000, 32'h3e000000, 32'h3f400000,
            32'h3e000000, 32'h3e000000, 32'h3e000000, 3'd3, 32'h3f400000, 1'b1);
    run_vec("nan_all", 32'h7fc00000, 32'h7fc00000, 32'h7fc00000, 32'h7fc00000,
            32'h7fc00000, 32'h7fc00000, 32'h7fc00000, 3'd0, 32'h7fc00000, 1'b1);
    run_vec("inf", 32'h00000001, 32'h80000001, 32'h3f800000, 32'hff800000,
            32'h7f7fffff, 32'h7f800000, 32'h00000000, 3'd5, 32'h7f800000, 1'b0);
    run_vec("denorm", 32'h80000002, 32'h80000001, 32'h00000000, 32'h00000001,
            32'h80000000, 32'hff800000, 32'h00000001, 3'd3, 32'h00000001, 1'b0);

    // valid_in held high with fresh data while busy: second capture lands one edge after valid_out.
    set_vec(32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h40a00000, 32'h40c00000, 32'h40e00000);
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    set_vec(32'h3f800000, 32'h41000000, 32'h3f800000, 32'h3f800000,
            32'h3f800000, 32'h3f800000, 32'h3f800000);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("busy valid_out_e%0d", k), {31'd0, bus.valid_out},
            (k == 7 || k == 15) ? 32'd1 : 32'd0);
      if (k == 7) begin
        check("busy first idx", {29'd0, bus.class_idx}, 32'd6);
        check("busy first max", bus.max_val, 32'h40e00000);
      end
      if (k == 8) begin
        check("busy recapture ready", {31'd0, bus.ready}, 32'd0);
        bus.valid_in = 1'b0;
      end
      if (k == 15) begin
        check("busy second idx", {29'd0, bus.class_idx}, 32'd1);
        check("busy second max", bus.max_val, 32'h41000000);
      end
    end

    // Reset asserted in the middle of a scan.
    set_vec(32'h7fc00000, 32'h3e000000, 32'h3e000000, 32'h3f400000,
            32'h3e000000, 32'h3e000000, 32'h3e000000);
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort ready", {31'd0, bus.ready}, 32'd1);
    check("abort valid_out", {31'd0, bus.valid_out}, 32'd0);
    check("abort class_idx", {29'd0, bus.class_idx}, 32'd0);
    check("abort max_val", bus.max_val, 32'd0);
    check("abort nan_flag", {31'd0, bus.nan_flag}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort quiet_e%0d", k), {31'd0, bus.valid_out}, 32'd0);
    end
    run_vec("after_rst", 32'hc0000000, 32'hc0400000, 32'hc0400000, 32'hc0400000,
            32'hbf800000, 32'hc0400000, 32'hc0400000, 3'd4, 32'hbf800000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
